// File: rtl/alu_share_arb_pkg.sv
// alu_pkg: shared definitions for the two-port ALU time-share arbiter.
// Contents: ALU opcode constants, arbiter FSM state type, opcode legality helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_XNOR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // True for the six opcodes the shared ALU implements.
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR};
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_grant2.sv
// rr_grant2: two-requester round-robin grant.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   valid_i[1:0]  : requester valids
//   accept_i      : the granted request was taken this cycle
//   grant_o[1:0]  : one-hot grant (all zero when nobody is valid)
// The pointer names the requester that wins a tie; after an accept it moves
// to the requester that did not win.
module rr_grant2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Winner 0 hands priority to 1 and vice versa.
  assign ptr_d = accept_i ? grant_o[0] : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one combinational ALU between two requesters.
// A request is granted round-robin in IDLE, its operands are registered and
// held on the ALU pins, the ALU output is captured one cycle later (EXEC) and
// returned on the winner's response handshake (RESP).
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   reqN_valid/ready/op/a/b     : request handshake and payload, N = 0,1
//   rspN_valid/ready/result/err : response handshake and payload, N = 0,1
//   alu_i, alu_a, alu_b         : drive the external ALU
//   alu_result                  : external ALU output
// Build option: define ALU_ARB_OPCHECK_EN to reject unsupported opcodes with
// rspN_err=1 and result 0, bypassing EXEC; otherwise every opcode is executed
// and rspN_err is tied low.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_err,
  output logic [3:0]       alu_i,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  arb_state_e       state_q;
  logic             winner_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       rsp_valid_q;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       grant;
  logic [1:0]       req_ready;
  logic             accept;
  logic             win;
  logic [3:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  rr_grant2 u_rr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (req_valid),
    .accept_i(accept),
    .grant_o (grant)
  );

  // Grant is only ever set for a valid requester, so any ready is an accept.
  assign req_ready  = (state_q == ST_IDLE) ? grant : 2'b00;
  assign accept     = |req_ready;
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  assign win   = grant[1];
  assign op_in = win ? req1_op : req0_op;
  assign a_in  = win ? req1_a  : req0_a;
  assign b_in  = win ? req1_b  : req0_b;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      winner_q    <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            winner_q <= win;
`ifdef ALU_ARB_OPCHECK_EN
            // Rejected ops never reach the ALU pins; answer directly.
            if (!op_legal(op_in)) begin
              result_q    <= '0;
              err_q       <= 1'b1;
              rsp_valid_q <= grant;
              state_q     <= ST_RESP;
            end else
`endif
            begin
              op_q    <= op_in;
              a_q     <= a_in;
              b_q     <= b_in;
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          result_q    <= alu_result;
`ifdef ALU_ARB_OPCHECK_EN
          err_q       <= 1'b0;
`endif
          rsp_valid_q <= winner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (|(rsp_valid_q & rsp_ready)) begin
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_i = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;

  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;

`ifdef ALU_ARB_OPCHECK_EN
  assign rsp0_err = err_q;
  assign rsp1_err = err_q;
`else
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op[2];
  logic [W-1:0] req_a[2];
  logic [W-1:0] req_b[2];
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result[2];
  logic [1:0]   rsp_err;
  logic [3:0]   alu_i;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_op    (req_op[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_op    (req_op[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_result(rsp_result[0]),
    .rsp0_err   (rsp_err[0]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_result(rsp_result[1]),
    .rsp1_err   (rsp_err[1]),
    .alu_i      (alu_i),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // Behavioural ALU sitting next to the arbiter; undefined opcodes return junk.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return ~(a ^ b);
      default: return 32'hDEAD_0000 ^ a;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_i, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin
      req_op[n] = 4'd0;
      req_a[n]  = '0;
      req_b[n]  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drive one request and wait for its response; lat counts cycles from the
  // accepting edge to the first sample with rsp valid (-1 on timeout).
  task automatic send(input int id, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int lat);
    bit got;
    req_op[id] = op;
    req_a[id]  = a;
    req_b[id]  = b;
    req_valid[id] = 1'b1;
    lat = -1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    req_valid[id] = 1'b0;
    if (got) begin
      for (int k = 1; k <= 6; k++) begin
        #1;
        if (rsp_valid[id]) begin
          lat = k;
          break;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    n_checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: ready=%b rsp_valid=%b expected 00/00", req_ready, rsp_valid);
    end
    n_checks++;
    if (rsp_err !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected 00", rsp_err);
    end
    n_checks++;
    if (rsp_result[0] !== '0 || rsp_result[1] !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h/%h expected 0", rsp_result[0], rsp_result[1]);
    end
    n_checks++;
    if (alu_i !== 4'd0 || alu_a !== '0 || alu_b !== '0) begin
      n_fail++;
      $display("FAIL reset_alu: i=%h a=%h b=%h expected 0", alu_i, alu_a, alu_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lat;
    send(0, OP_ADD, 32'd5, 32'd7, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected 2", lat);
    end
    n_checks++;
    if (rsp_result[0] !== 32'd12 || rsp_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got %h err %b expected 0000000c err 0", rsp_result[0], rsp_err[0]);
    end
    n_checks++;
    if (rsp_valid[1] !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      n_fail++;
      $display("FAIL single_route: rsp1_valid=%b alu_a=%h alu_b=%h expected 0/5/7", rsp_valid[1], alu_a, alu_b);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_release: rsp_valid=%b expected 00", rsp_valid);
    end
  endtask

  task automatic test_contention();
    int g;
    int last_c;
    int gid[4];
    do_reset();
    req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
    req_op[1] = OP_SUB; req_a[1] = 32'd3; req_b[1] = 32'd5;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    g = 0;
    last_c = -1;
    for (int c = 0; c < 40 && g < 4; c++) begin
      #1;
      if (rsp_valid[1]) begin
        n_checks++;
        if (rsp_result[1] !== 32'hFFFF_FFFE) begin
          n_fail++;
          $display("FAIL contention_sub: got %h expected fffffffe", rsp_result[1]);
        end
      end
      if (rsp_valid[0]) begin
        n_checks++;
        if (rsp_result[0] !== 32'd3) begin
          n_fail++;
          $display("FAIL contention_add: got %h expected 00000003", rsp_result[0]);
        end
      end
      if (req_ready !== 2'b00) begin
        gid[g] = req_ready[1] ? 1 : 0;
        n_checks++;
        if (req_ready !== (g % 2 == 0 ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL contention_grant%0d: ready=%b expected requester %0d", g, req_ready, g % 2);
        end
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c != 3) begin
            n_fail++;
            $display("FAIL contention_interval: got %0d cycles expected 3", c - last_c);
          end
        end
        last_c = c;
        g++;
      end
      tick();
    end
    n_checks++;
    if (g != 4) begin
      n_fail++;
      $display("FAIL contention_timeout: got %0d grants expected 4", g);
    end
    req_valid = 2'b00;
    repeat (3) tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back_backpressure();
    int lat;
    rsp_ready = 2'b00;
    send(1, OP_ADD, 32'd10, 32'd20, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected 2", lat);
    end
    req_op[0] = OP_OR; req_a[0] = 32'h10; req_b[0] = 32'h01;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== 32'd30 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d: rsp1_valid=%b result=%h ready=%b expected 1/0000001e/00",
                 c, rsp_valid[1], rsp_result[1], req_ready);
      end
      tick();
    end
    rsp_ready[1] = 1'b1;
    #1;
    n_checks++;
    if (req_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_early_accept: req0_ready=%b expected 0", req_ready[0]);
    end
    tick();
    rsp_ready[1] = 1'b0;
    n_checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_after_handshake: rsp1_valid=%b req0_ready=%b expected 0/1", rsp_valid[1], req_ready[0]);
    end
    tick();
    req_valid[0] = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'h11) begin
      n_fail++;
      $display("FAIL bp_next_result: valid=%b result=%h expected 1/00000011", rsp_valid[0], rsp_result[0]);
    end
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_logic_ops();
    int lat;
    logic [W-1:0] exp_l[4];
    exp_l = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'hF00F_F00F};
    for (int i = 0; i < 4; i++) begin
      send(0, 4'(8 + i), 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
      n_checks++;
      if (lat !== 2 || rsp_result[0] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL logic_op%0d: lat=%0d result=%h expected lat 2 result %h", 8 + i, lat, rsp_result[0], exp_l[i]);
      end
      rsp_ready[0] = 1'b1;
      tick();
      rsp_ready[0] = 1'b0;
    end
  endtask

  task automatic test_opcheck();
    int lat;
    logic [3:0] prev_i;
    prev_i = alu_i;
    send(1, 4'd5, 32'h1234, 32'h0002, lat);
`ifdef ALU_ARB_OPCHECK_EN
    n_checks++;
    if (lat !== 1 || rsp_err[1] !== 1'b1 || rsp_result[1] !== '0) begin
      n_fail++;
      $display("FAIL opcheck_reject: lat=%0d err=%b result=%h expected 1/1/0", lat, rsp_err[1], rsp_result[1]);
    end
    n_checks++;
    if (alu_i !== prev_i || alu_a === 32'h1234) begin
      n_fail++;
      $display("FAIL opcheck_alu_untouched: alu_i=%h alu_a=%h expected alu_i %h", alu_i, alu_a, prev_i);
    end
`else
    n_checks++;
    if (lat !== 2 || rsp_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL opcheck_off: lat=%0d err=%b expected 2/0 (prev op %h)", lat, rsp_err[1], prev_i);
    end
`endif
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    // A legal op right after must clear the error flag.
    send(1, OP_XOR, 32'h0F, 32'hFF, lat);
    n_checks++;
    if (lat !== 2 || rsp_err[1] !== 1'b0 || rsp_result[1] !== 32'hF0) begin
      n_fail++;
      $display("FAIL opcheck_recover: lat=%0d err=%b result=%h expected 2/0/000000f0", lat, rsp_err[1], rsp_result[1]);
    end
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_midop();
    int lat;
    // Leave the pointer favouring requester 1, then abort an op in flight.
    send(0, OP_ADD, 32'd1, 32'd1, lat);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    req_op[0] = OP_ADD; req_a[0] = 32'h55; req_b[0] = 32'h1;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_handshake: rsp_valid=%b ready=%b expected 00/00", rsp_valid, req_ready);
    end
    n_checks++;
    if (alu_a !== '0 || rsp_result[0] !== '0) begin
      n_fail++;
      $display("FAIL midop_discard: alu_a=%h result=%h expected 0/0", alu_a, rsp_result[0]);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_no_stale_rsp: rsp_valid=%b expected 00", rsp_valid);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_pointer: ready=%b expected 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_req1_alone: ready=%b expected 10", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] legal_ops[6];
    bit         m_busy;
    int         m_phase;
    int         m_id;
    int         m_ptr;
    int         win;
    int         n_done;
    logic [W-1:0] m_res;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR};
    do_reset();
    m_busy = 1'b0;
    m_phase = 0;
    m_id = 0;
    m_ptr = 0;
    m_res = '0;
    n_done = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] && $urandom_range(0, 2) == 0) begin
          req_valid[n] = 1'b1;
          req_op[n] = legal_ops[$urandom_range(0, 5)];
          req_a[n] = $urandom;
          req_b[n] = $urandom;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      exp_rdy = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b11) exp_rdy = (m_ptr == 1) ? 2'b10 : 2'b01;
        else                    exp_rdy = req_valid;
      end
      exp_rv = (m_busy && m_phase >= 2) ? ((m_id == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, exp_rdy);
      end
      n_checks++;
      if (rsp_valid !== exp_rv) begin
        n_fail++;
        $display("FAIL rand_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        n_checks++;
        if (rsp_result[m_id] !== m_res || rsp_err[m_id] !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_result c%0d: got %h err %b expected %h err 0", c, rsp_result[m_id], rsp_err[m_id], m_res);
        end
      end
      win = -1;
      if (exp_rdy != 2'b00) begin
        win = exp_rdy[1] ? 1 : 0;
        m_busy = 1'b1;
        m_phase = 1;
        m_id = win;
        m_res = ref_alu(req_op[win], req_a[win], req_b[win]);
        m_ptr = 1 - win;
      end else if (m_busy) begin
        if (m_phase >= 2 && rsp_ready[m_id]) begin
          m_busy = 1'b0;
          n_done++;
        end else if (m_phase < 2) begin
          m_phase++;
        end
      end
      tick();
      if (win >= 0) req_valid[win] = 1'b0;
    end
    n_checks++;
    if (n_done < 50) begin
      n_fail++;
      $display("FAIL rand_throughput: got %0d responses expected at least 50", n_done);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back_backpressure();
    test_logic_ops();
    test_opcheck();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
